// File: rtl/fifo_reader.sv
// Pop-side burst controller for the counter-based FIFO, presenting popped words on a valid/ready stream.
// Build option: define FIFO_READER_SKID_EN for a 2-entry skid buffer instead of a single output register.
module fifo_reader #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 2,
   parameter int THRESHOLD = 1,
   parameter int BURST     = DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH):0]   fifo_item_count,
   input  logic [WIDTH-1:0]         fifo_pop_data,
   output logic                     fifo_pop_enable,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_last,
   output logic                     burst_active
);

   localparam int L2_DEPTH = $clog2(DEPTH);
   localparam int CNT_W    = L2_DEPTH + 1;
   localparam int BW       = $clog2(BURST) + 1;

   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [BW-1:0]    BURST_LAST = BW'(BURST - 1);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
   logic            room;
   logic            pop;
   logic            last;
   logic            count_nz;
   logic            start;

   // Stream handshake: a word transfers on any rising edge where m_valid && m_ready;
   // m_data/m_last are only meaningful while m_valid is high and never change under stall.

   always_comb begin
      count_nz      = (fifo_item_count != '0);
      start         = (fifo_item_count >= THRESH_C) || (flush && count_nz);
      last          = (burst_cnt == BURST_LAST) || (fifo_item_count == ONE_C);
      pop           = 1'b0;
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      case (state)
         IDLE: begin
            burst_cnt_nxt = '0;
            if (start) state_nxt = STREAM;
         end
         STREAM: begin
            pop = count_nz && room;
            if (pop) begin
               if (last) begin
                  state_nxt     = IDLE;
                  burst_cnt_nxt = '0;
               end else begin
                  burst_cnt_nxt = burst_cnt + 1'b1;
               end
            end else if (!count_nz) begin
               // Defensive exit: the FIFO drained without a last pop being seen.
               state_nxt = IDLE;
            end
         end
      endcase
      if (rst) pop = 1'b0;
   end

   assign fifo_pop_enable = pop;
   assign burst_active    = (state == STREAM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

`ifdef FIFO_READER_SKID_EN
   logic [1:0]       occ;
   logic [WIDTH-1:0] data0, data1;
   logic             last0, last1;
   logic             accept;

   // Room depends only on occupancy, which breaks the m_ready -> pop path.
   assign room    = (occ != 2'd2);
   assign accept  = (occ != 2'd0) && m_ready;
   assign m_valid = (occ != 2'd0);
   assign m_data  = data0;
   assign m_last  = last0;

   always_ff @(posedge clk) begin
      if (rst) begin
         occ   <= 2'd0;
         data0 <= '0;
         data1 <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
      end else begin
         case ({pop, accept})
            2'b11: begin
               data0 <= fifo_pop_data;
               last0 <= last;
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  data0 <= fifo_pop_data;
                  last0 <= last;
               end else begin
                  data1 <= fifo_pop_data;
                  last1 <= last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               last0 <= last1;
               occ   <= occ - 2'd1;
            end
            default: ;
         endcase
      end
   end
`else
   assign room = !m_valid || m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (pop) begin
         m_valid <= 1'b1;
         m_data  <= fifo_pop_data;
         m_last  <= last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO, queue-based reader model checked every cycle, directed plus random steps.
module tb_fifo_reader;

   localparam int WIDTH     = 4;
   localparam int DEPTH     = 4;
   localparam int THRESHOLD = 2;
   localparam int BURST     = 2;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic [CNT_W-1:0]    fifo_item_count;
   logic [WIDTH-1:0]    fifo_pop_data;
   logic                fifo_pop_enable;
   logic                flush;
   logic                m_valid;
   logic                m_ready;
   logic [WIDTH-1:0]    m_data;
   logic                m_last;
   logic                burst_active;

   always #5 clk = ~clk;

   fifo_reader #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .BURST(BURST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_item_count(fifo_item_count),
      .fifo_pop_data(fifo_pop_data),
      .fifo_pop_enable(fifo_pop_enable),
      .flush(flush),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .m_last(m_last),
      .burst_active(burst_active)
   );

   // Environment FIFO contents (head at index 0)
   logic [WIDTH-1:0] fifo_q[$];
   // Reference model: words held in output storage as {last, data}
   logic [WIDTH:0]   exp_q[$];
   bit               mdl_burst;
   int               mdl_words;
   bit               post_rst;
   // Words the consumer accepted, compared against constant lists after directed steps
   logic [WIDTH:0]   got_q[$];
   logic [WIDTH:0]   want_q[$];

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit push, input logic [WIDTH-1:0] pdata,
                       input bit fl, input bit rdy);
      int  c;
      bit  room;
      bit  exp_pop;
      bit  dut_pop;
      bit  lastf;
      rst     = r;
      flush   = fl;
      m_ready = rdy;
      c = fifo_q.size();
      fifo_item_count = CNT_W'(c);
      fifo_pop_data   = (c != 0) ? fifo_q[0] : '0;
      @(negedge clk);
`ifdef FIFO_READER_SKID_EN
      room = (exp_q.size() < 2);
`else
      room = (exp_q.size() == 0) || rdy;
`endif
      exp_pop = !r && mdl_burst && (c != 0) && room;
      check("pop_enable", fifo_pop_enable, exp_pop);
      check("m_valid", m_valid, exp_q.size() != 0);
      check("burst_active", burst_active, mdl_burst);
      if (exp_q.size() != 0) begin
         check("m_data", m_data, exp_q[0][WIDTH-1:0]);
         check("m_last", m_last, exp_q[0][WIDTH]);
      end else if (post_rst) begin
         check("m_data_reset", m_data, 0);
         check("m_last_reset", m_last, 0);
      end
      if (fifo_pop_enable) check("pop_on_empty", c != 0, 1);
      dut_pop = fifo_pop_enable;
      if (!r && m_valid && rdy) got_q.push_back({m_last, m_data});
      @(posedge clk);
      #1;
      if (r) begin
         fifo_q.delete();
      end else begin
         if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
         if (push && fifo_q.size() < DEPTH) fifo_q.push_back(pdata);
      end
      if (r) begin
         exp_q.delete();
         mdl_burst = 1'b0;
         mdl_words = 0;
         post_rst  = 1'b1;
      end else begin
         if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
         if (exp_pop) begin
            lastf = (mdl_words == BURST - 1) || (c == 1);
            exp_q.push_back({lastf, fifo_pop_data});
            post_rst = 1'b0;
            mdl_words++;
            if (lastf) begin
               mdl_burst = 1'b0;
               mdl_words = 0;
            end
         end else if (mdl_burst && c == 0) begin
            mdl_burst = 1'b0;
         end else if (!mdl_burst && (c >= THRESHOLD || (fl && c != 0))) begin
            mdl_burst = 1'b1;
            mdl_words = 0;
         end
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy);
   endtask

   task automatic compare_words(input string tag);
      check({tag, "_count"}, got_q.size(), want_q.size());
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         check(tag, got_q[i], want_q[i]);
      got_q.delete();
      want_q.delete();
   endtask

   initial begin
      rst             = 1'b1;
      flush           = 1'b0;
      m_ready         = 1'b0;
      fifo_item_count = '0;
      fifo_pop_data   = '0;
      mdl_burst       = 1'b0;
      mdl_words       = 0;
      post_rst        = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);

      // One word below threshold waits; the second starts a two-word burst
      step(1'b0, 1'b1, 4'h1, 1'b0, 1'b1);
      idle(3, 1'b1);
      step(1'b0, 1'b1, 4'h2, 1'b0, 1'b1);
      idle(4, 1'b1);
      want_q = '{5'h01, 5'h12};
      compare_words("thresh_burst");

      // Burst cap splits A,B | C; C is released by flush
      step(1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hB, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'hC, 1'b0, 1'b1);
      idle(4, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle(3, 1'b1);
      want_q = '{5'h0A, 5'h1B, 5'h1C};
      compare_words("burst_cap");

      // Consumer stall mid-burst
      step(1'b0, 1'b1, 4'h3, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'h4, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      want_q = '{5'h03, 5'h14, 5'h06, 5'h17};
      compare_words("stall");

      // Flush with a single word, then flush on an empty FIFO
      step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1);
      idle(2, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle(3, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle(2, 1'b1);
      want_q = '{5'h15};
      compare_words("flush");

      // Empty FIFO with a toggling consumer
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      compare_words("empty_idle");

      // Reset while a word is held
      step(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
      for (int k = 0; k < 10 && !m_valid; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("valid_before_reset", m_valid, 1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("reset_fifo_empty", fifo_item_count, 0);
      got_q.delete();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) != 0));
      end
      idle(10, 1'b1);
      got_q.delete();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
